// File: rtl/grid_erosion_engine_if.sv
// Load, control, status and readback bundle for the grid erosion engine.
// master drives rows/commands and reads status; slave is the engine.
interface grid_erosion_engine_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int SW    = 8,
  parameter int CW    = $clog2(WIDTH*DEPTH+1),
  parameter int AW    = $clog2(DEPTH)
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_row;
  logic             start;
  logic             conn8;
  logic [3:0]       thresh;
  logic [SW-1:0]    max_sweeps;
  logic             clear;
  logic             busy;
  logic             done;
  logic             truncated;
  logic [CW-1:0]    first_removed;
  logic [CW-1:0]    total_removed;
  logic [SW-1:0]    sweeps;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_row;

  modport master (
    output load_valid, load_row, start, conn8, thresh, max_sweeps, clear, rd_addr,
    input  load_ready, busy, done, truncated, first_removed, total_removed, sweeps, rd_row
  );

  modport slave (
    input  load_valid, load_row, start, conn8, thresh, max_sweeps, clear, rd_addr,
    output load_ready, busy, done, truncated, first_removed, total_removed, sweeps, rd_row
  );
endinterface

// File: rtl/grid_erosion_engine.sv
// Iterative grid erosion: rows load one per beat (load_ready high only in IDLE), then one
// whole-grid Jacobi sweep per clock until a sweep removes nothing or the sweep limit is hit.
module grid_erosion_engine #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int SW    = 8,
  localparam int CW   = $clog2(WIDTH*DEPTH+1),
  localparam int AW   = $clog2(DEPTH)
) (
  input logic                clk,
  input logic                rst_n,
  grid_erosion_engine_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] grid_q [DEPTH];
  logic [WIDTH-1:0] grid_d [DEPTH];
  logic [WIDTH-1:0] next_grid [DEPTH];
  logic [WIDTH+1:0] pad [DEPTH+2];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic             conn8_q, conn8_d;
  logic [3:0]       thresh_q, thresh_d;
  logic [SW-1:0]    max_q, max_d;
  logic [CW-1:0]    first_q, first_d;
  logic [CW-1:0]    total_q, total_d;
  logic [SW-1:0]    sweeps_q, sweeps_d;
  logic [SW-1:0]    sweeps_inc;
  logic             trunc_q, trunc_d;
  logic [CW-1:0]    rem_cnt;

  // Zero border so edge cells see out-of-grid neighbours as empty.
  always_comb begin
    for (int r = 0; r < DEPTH + 2; r++) pad[r] = '0;
    for (int r = 0; r < DEPTH; r++) pad[r+1] = {1'b0, grid_q[r], 1'b0};
  end

  always_comb begin
    logic [3:0] nb;
    logic       kill;
    rem_cnt = '0;
    nb      = '0;
    kill    = 1'b0;
    for (int r = 0; r < DEPTH; r++) next_grid[r] = grid_q[r];
    for (int r = 0; r < DEPTH; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        nb = 4'(pad[r][c+1]) + 4'(pad[r+2][c+1]) + 4'(pad[r+1][c]) + 4'(pad[r+1][c+2]);
        if (conn8_q)
          nb = nb + 4'(pad[r][c]) + 4'(pad[r][c+2]) + 4'(pad[r+2][c]) + 4'(pad[r+2][c+2]);
        kill = grid_q[r][c] && (nb < thresh_q);
        next_grid[r][c] = grid_q[r][c] & ~kill;
        rem_cnt = rem_cnt + CW'(kill);
      end
    end
  end

  assign sweeps_inc = (&sweeps_q) ? sweeps_q : sweeps_q + SW'(1);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    conn8_d  = conn8_q;
    thresh_d = thresh_q;
    max_d    = max_q;
    first_d  = first_q;
    total_d  = total_q;
    sweeps_d = sweeps_q;
    trunc_d  = trunc_q;
    for (int r = 0; r < DEPTH; r++) grid_d[r] = grid_q[r];

    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          grid_d[wr_ptr_q] = bus.load_row;
          if (wr_ptr_q == AW'(DEPTH - 1)) begin
            wr_ptr_d = '0;
            state_d  = LOADED;
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end
      end
      LOADED: begin
        if (bus.start) begin
          state_d  = RUN;
          conn8_d  = bus.conn8;
          thresh_d = bus.thresh;
          max_d    = bus.max_sweeps;
          first_d  = '0;
          total_d  = '0;
          sweeps_d = '0;
          trunc_d  = 1'b0;
        end
      end
      RUN: begin
        if (rem_cnt == '0) begin
          state_d = DONE;
        end else begin
          for (int r = 0; r < DEPTH; r++) grid_d[r] = next_grid[r];
          total_d  = total_q + rem_cnt;
          sweeps_d = sweeps_inc;
          if (sweeps_q == '0) first_d = rem_cnt;
          if ((max_q != '0) && (sweeps_inc == max_q)) begin
            state_d = DONE;
            trunc_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // clear outranks start and load beats in the same cycle.
    if (bus.clear) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      conn8_d  = 1'b0;
      thresh_d = '0;
      max_d    = '0;
      first_d  = '0;
      total_d  = '0;
      sweeps_d = '0;
      trunc_d  = 1'b0;
      for (int r = 0; r < DEPTH; r++) grid_d[r] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      conn8_q  <= 1'b0;
      thresh_q <= '0;
      max_q    <= '0;
      first_q  <= '0;
      total_q  <= '0;
      sweeps_q <= '0;
      trunc_q  <= 1'b0;
      for (int r = 0; r < DEPTH; r++) grid_q[r] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      conn8_q  <= conn8_d;
      thresh_q <= thresh_d;
      max_q    <= max_d;
      first_q  <= first_d;
      total_q  <= total_d;
      sweeps_q <= sweeps_d;
      trunc_q  <= trunc_d;
      for (int r = 0; r < DEPTH; r++) grid_q[r] <= grid_d[r];
    end
  end

  assign bus.load_ready    = (state_q == IDLE);
  assign bus.busy          = (state_q == RUN);
  assign bus.done          = (state_q == DONE);
  assign bus.truncated     = trunc_q;
  assign bus.first_removed = first_q;
  assign bus.total_removed = total_q;
  assign bus.sweeps        = sweeps_q;
  assign bus.rd_row        = (32'(bus.rd_addr) < DEPTH) ? grid_q[bus.rd_addr] : '0;

endmodule

// File: doc/grid_erosion_engine.md
Name: grid_erosion_engine

Overview:
- Iterative, parametrised removal engine for a binary occupancy grid (1 = roll, 0 = empty).
- Loads a WIDTH x DEPTH grid row by row, then runs one full-grid synchronous sweep per clock. Each sweep removes every occupied cell whose occupied-neighbour count is below a runtime threshold.
- Stops when a sweep removes nothing or a sweep limit is hit. Reports first-sweep count, total count and sweep count; final grid is readable.
- Successor of the single-sweep removal unit, adding load handshake, runtime threshold, 4/8-connectivity mode and iteration control.

Parameters:
- WIDTH, 16, columns per row (>=2).
- DEPTH, 16, rows (>=2).
- SW, 8, sweep counter width.
- CW, $clog2(WIDTH*DEPTH+1), count width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  row beat valid.
- load_ready  out  1  engine accepts a row beat.
- load_row  in  WIDTH  row data; bit j = column j.
- start  in  1  one-cycle pulse, begin erosion.
- conn8  in  1  1 = 8-neighbour, 0 = 4-neighbour (sampled at start).
- thresh  in  4  remove if neighbours < thresh (sampled at start).
- max_sweeps  in  SW  sweep limit; 0 = unlimited (sampled at start).
- clear  in  1  return to IDLE, discard grid.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- truncated  out  1  DONE reached via max_sweeps.
- first_removed  out  CW  cells removed in sweep 1.
- total_removed  out  CW  cells removed across all sweeps.
- sweeps  out  SW  sweeps that removed >=1 cell.
- rd_addr  in  $clog2(DEPTH)  readback row index.
- rd_row  out  WIDTH  grid row rd_addr, combinational; valid in LOADED/DONE.

Behaviour:
- Reset (async, rst_n=0): state IDLE, grid all 0, wr_ptr 0, all counts 0, busy/done/truncated 0, load_ready 1.
- States:
  - IDLE, accepting rows.
  - LOADED, DEPTH rows held.
  - RUN.
  - DONE.
- IDLE:
  - load_ready=1. Beat on load_valid&load_ready writes row wr_ptr, then wr_ptr++.
  - The beat writing row DEPTH-1 -> LOADED, wr_ptr -> 0.
  - start ignored in IDLE.
- LOADED:
  - load_ready=0. start -> RUN next cycle; conn8/thresh/max_sweeps latched; counts cleared.
- RUN, one sweep per cycle:
  - Neighbour count uses the pre-sweep grid only (Jacobi). Out-of-grid neighbours count as 0.
  - 8-conn uses 8 neighbours; 4-conn uses N/S/E/W only.
  - Occupied cell with count < thresh_latched is cleared. Removal count r computed with a CW-bit adder tree.
  - If r=0: DONE, grid/counts unchanged, sweeps not incremented.
  - Else: grid <= next, total_removed += r, sweeps++. If sweeps was 0, first_removed <= r.
  - If max_sweeps_latched != 0 and the incremented sweeps == max_sweeps_latched: DONE with truncated=1.
  - thresh=0 -> first sweep removes nothing -> DONE immediately.
  - thresh>8 (or >4 in 4-conn) removes every occupied cell in sweep 1.
- DONE:
  - done=1; counts and grid held; start ignored.
- clear (any state except reset):
  - next cycle IDLE, grid zeroed, wr_ptr 0, counts 0, flags 0.
  - clear beats start and load in the same cycle.
- total_removed never exceeds WIDTH*DEPTH; no wrap by construction.
- sweeps saturates at 2^SW-1; after saturation, further sweeps still update grid/total.
- Async reset mid-RUN aborts immediately, to the reset state.

Test Plan:
- WIDTH=DEPTH=3, load 111/111/111, conn8=1, thresh=4, max_sweeps=0, start:
  - -> busy for 4 cycles, done=1, first_removed=4, total_removed=9, sweeps=3, truncated=0, rd_row all 000.
- Same grid, conn8=0, thresh=4:
  - -> first_removed=8, total_removed=9, sweeps=2, done after 3 RUN cycles.
- Same grid, conn8=1, thresh=4, max_sweeps=1:
  - -> done after 1 cycle, truncated=1, total_removed=4, rd_row(0..2) = 010/111/010.
- Empty 3x3 grid, start:
  - -> done after 1 RUN cycle, total_removed=0, first_removed=0, sweeps=0.
- Load 2 rows, assert start:
  - -> ignored, busy=0. Third beat -> LOADED, load_ready=0; extra load_valid beats not accepted.
- rst_n low during RUN sweep 2 of the first scenario:
  - -> outputs zero immediately, load_ready=1.
  - After reload + start, the first-scenario results are reproduced exactly.
